shared_tlb_arbiter: RTL and testbench
=====================================

Name: shared_tlb_arbiter

Overview:
Arbitrates ITLB-miss and DTLB-miss requests onto the single shared second-level TLB and, on a shared-TLB miss, onto the page-table walker. It sits between the two first-level TLBs and the shared TLB/PTW inside the MMU. It serialises one translation at a time and returns the result to the requester that won arbitration. Flushes are handled without corrupting the in-flight PTW transaction.

Parameters:
VpnWidth, 20, virtual page number width (Sv32)
PpnWidth, 22, physical page number width (Sv32)
AsidWidth, 9, address-space identifier width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
flush_i  in  1  abort current translation (sfence.vma / pipeline flush)
asid_i  in  AsidWidth  current ASID
itlb_req_i  in  1  ITLB miss request, level, held until itlb_resp_o or flush
itlb_vpn_i  in  VpnWidth  ITLB miss VPN
dtlb_req_i  in  1  DTLB miss request, level, held until dtlb_resp_o or flush
dtlb_vpn_i  in  VpnWidth  DTLB miss VPN
itlb_resp_o  out  1  one-cycle response pulse to ITLB
dtlb_resp_o  out  1  one-cycle response pulse to DTLB
resp_ppn_o  out  PpnWidth  translated PPN, valid with a resp pulse
resp_err_o  out  1  page fault/access error, valid with a resp pulse
stlb_lookup_o  out  1  shared-TLB lookup strobe
stlb_vpn_o  out  VpnWidth  lookup VPN
stlb_asid_o  out  AsidWidth  lookup ASID
stlb_hit_i  in  1  shared-TLB hit, valid the cycle after stlb_lookup_o
stlb_ppn_i  in  PpnWidth  shared-TLB PPN, valid with stlb_hit_i
ptw_req_o  out  1  walk request, held until ptw_ack_i
ptw_vpn_o  out  VpnWidth  walk VPN
ptw_is_instr_o  out  1  walk is for the ITLB
ptw_ack_i  in  1  PTW accepted the request
ptw_done_i  in  1  walk complete, one-cycle pulse
ptw_ppn_i  in  PpnWidth  walk result PPN
ptw_err_i  in  1  walk fault
stlb_miss_o  out  1  perf event pulse, one per shared-TLB miss
busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; rr_ptr = 0 (DTLB favoured); latched vpn/asid/ppn/err/owner = 0.
- States: IDLE, LOOKUP, CHECK, PTW_REQ, PTW_WAIT, RESP, DRAIN.
- IDLE: if any request is present, grant it. If both are present, the side not granted last wins (rr_ptr). rr_ptr=0 favours DTLB. Latch owner, vpn and asid_i, then go to LOOKUP. rr_ptr updates to the winner at grant time.
- LOOKUP: stlb_lookup_o=1 with latched vpn/asid; go to CHECK.
- CHECK: if stlb_hit_i, latch stlb_ppn_i and err=0, go to RESP. Otherwise pulse stlb_miss_o and go to PTW_REQ.
- PTW_REQ: ptw_req_o=1, ptw_vpn_o=latched vpn, ptw_is_instr_o=(owner==ITLB). On ptw_ack_i go to PTW_WAIT. ptw_ack_i and ptw_done_i arriving in the same cycle is treated as ack+done: latch the result and go to RESP.
- PTW_WAIT: on ptw_done_i, latch ptw_ppn_i/ptw_err_i and go to RESP.
- RESP: exactly one of itlb_resp_o/dtlb_resp_o = 1, selected by owner. resp_ppn_o/resp_err_o come from the latches. Next state is IDLE. resp_ppn_o/resp_err_o are 0 outside RESP.
- Hit latency: request seen in cycle 0 → lookup in cycle 1 → check in cycle 2 → resp in cycle 3 → next grant possible in cycle 4.
- Flush:
  - In IDLE, LOOKUP, CHECK or RESP: go to IDLE with no resp pulse. flush has priority over a RESP pulse in the same cycle.
  - In PTW_REQ: if ptw_ack_i is also high, go to DRAIN; otherwise drop ptw_req_o and go to IDLE.
  - In PTW_WAIT: go to DRAIN. If ptw_done_i is also high that cycle, go to IDLE instead.
- DRAIN: no resp. Wait for ptw_done_i, discard the result, then go to IDLE. New requests are not granted in DRAIN. Further flushes in DRAIN are ignored.
- A requester deasserting req without a flush is a protocol violation; the result is still delivered to it.
- stlb_lookup_o is at most one cycle per grant. ptw_req_o is never asserted outside PTW_REQ.

Test Plan:
- ITLB-only req, vpn=0x12345, stlb_hit_i=1 ppn=0x0ABCD in CHECK → itlb_resp_o pulse in cycle 3 with resp_ppn_o=0x0ABCD and err=0; dtlb_resp_o stays 0.
- dtlb_req_i and itlb_req_i raised together from reset, both hit → DTLB served first (resp in cycle 3), ITLB granted in cycle 4 (resp in cycle 7); repeated simultaneous requests alternate owners.
- DTLB req with stlb miss → stlb_miss_o one pulse; ptw_req_o held for 3 cycles until ptw_ack_i; ptw_is_instr_o=0; ptw_done_i with ppn=0x155 and err=1 → dtlb_resp_o with ppn 0x155, err=1.
- ITLB miss, flush_i in PTW_WAIT, ptw_done_i arrives 5 cycles later → no resp pulse; busy_o stays 1 until the done cycle; a DTLB request pending since the flush is granted the cycle after.
- flush_i in the RESP cycle → no resp pulse, IDLE next cycle; ptw_ack_i and ptw_done_i in the same PTW_REQ cycle → RESP next cycle with the PTW data.
- rst_ni asserted in PTW_WAIT → all outputs 0 immediately (asynchronously); after release, busy_o=0 and the first grant goes to DTLB.

Source files
------------

// File: rtl/shared_tlb_arbiter.sv
// shared_tlb_arbiter: serialises ITLB/DTLB misses onto the shared TLB and page-table walker
`timescale 1ns/1ps
module shared_tlb_arbiter #(
  parameter int VpnWidth  = 20,
  parameter int PpnWidth  = 22,
  parameter int AsidWidth = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic [AsidWidth-1:0] asid_i,
  input  logic                 itlb_req_i,
  input  logic [VpnWidth-1:0]  itlb_vpn_i,
  input  logic                 dtlb_req_i,
  input  logic [VpnWidth-1:0]  dtlb_vpn_i,
  output logic                 itlb_resp_o,
  output logic                 dtlb_resp_o,
  output logic [PpnWidth-1:0]  resp_ppn_o,
  output logic                 resp_err_o,
  output logic                 stlb_lookup_o,
  output logic [VpnWidth-1:0]  stlb_vpn_o,
  output logic [AsidWidth-1:0] stlb_asid_o,
  input  logic                 stlb_hit_i,
  input  logic [PpnWidth-1:0]  stlb_ppn_i,
  output logic                 ptw_req_o,
  output logic [VpnWidth-1:0]  ptw_vpn_o,
  output logic                 ptw_is_instr_o,
  input  logic                 ptw_ack_i,
  input  logic                 ptw_done_i,
  input  logic [PpnWidth-1:0]  ptw_ppn_i,
  input  logic                 ptw_err_i,
  output logic                 stlb_miss_o,
  output logic                 busy_o
);
  typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, PTW_REQ, PTW_WAIT, RESP, DRAIN} state_e;
  state_e                 state_q, state_d;
  logic                   owner_q, rr_q;
  logic [VpnWidth-1:0]    vpn_q;
  logic [AsidWidth-1:0]   asid_q;
  logic [PpnWidth-1:0]    ppn_q;
  logic                   err_q;
  logic                   grant, grant_d, stlb_take, ptw_take, resp_v;
  // owner/rr encoding: 1 = DTLB, 0 = ITLB; rr_q holds the last winner
  always_comb begin
    grant_d   = (itlb_req_i && dtlb_req_i) ? !rr_q : dtlb_req_i;
    grant     = state_q == IDLE && !flush_i && (itlb_req_i || dtlb_req_i);
    stlb_take = state_q == CHECK && stlb_hit_i && !flush_i;
    ptw_take  = (state_q == PTW_WAIT || (state_q == PTW_REQ && ptw_ack_i)) && ptw_done_i && !flush_i;
    state_d   = state_q;
    case (state_q)
      IDLE:     state_d = grant ? LOOKUP : IDLE;
      LOOKUP:   state_d = flush_i ? IDLE : CHECK;
      CHECK:    state_d = flush_i ? IDLE : stlb_hit_i ? RESP : PTW_REQ;
      PTW_REQ:  state_d = !ptw_ack_i ? (flush_i ? IDLE : PTW_REQ) :
                          ptw_done_i ? (flush_i ? IDLE : RESP) : (flush_i ? DRAIN : PTW_WAIT);
      PTW_WAIT: state_d = ptw_done_i ? (flush_i ? IDLE : RESP) : (flush_i ? DRAIN : PTW_WAIT);
      RESP:     state_d = IDLE;
      DRAIN:    state_d = ptw_done_i ? IDLE : DRAIN;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      vpn_q   <= '0;
      asid_q  <= '0;
      ppn_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= grant_d;
        rr_q    <= grant_d;
        vpn_q   <= grant_d ? dtlb_vpn_i : itlb_vpn_i;
        asid_q  <= asid_i;
      end
      if (stlb_take) begin
        ppn_q <= stlb_ppn_i;
        err_q <= 1'b0;
      end else if (ptw_take) begin
        ppn_q <= ptw_ppn_i;
        err_q <= ptw_err_i;
      end
    end
  end
  // a flush in the response cycle suppresses the pulse entirely
  always_comb begin
    resp_v         = state_q == RESP && !flush_i;
    itlb_resp_o    = resp_v && !owner_q;
    dtlb_resp_o    = resp_v && owner_q;
    resp_ppn_o     = resp_v ? ppn_q : '0;
    resp_err_o     = resp_v && err_q;
    stlb_lookup_o  = state_q == LOOKUP;
    stlb_vpn_o     = stlb_lookup_o ? vpn_q : '0;
    stlb_asid_o    = stlb_lookup_o ? asid_q : '0;
    ptw_req_o      = state_q == PTW_REQ;
    ptw_vpn_o      = ptw_req_o ? vpn_q : '0;
    ptw_is_instr_o = ptw_req_o && !owner_q;
    stlb_miss_o    = state_q == CHECK && !stlb_hit_i && !flush_i;
    busy_o         = state_q != IDLE;
  end
endmodule

// File: tb/tb_shared_tlb_arbiter.sv
// tb_shared_tlb_arbiter: directed scoreboard bench for the shared TLB arbiter
`timescale 1ns/1ps
module tb_shared_tlb_arbiter;
  logic        clk_i = 0, rst_ni = 0, flush_i = 0;
  logic [8:0]  asid_i = 9'h05;
  logic        itlb_req_i = 0, dtlb_req_i = 0;
  logic [19:0] itlb_vpn_i = 0, dtlb_vpn_i = 0;
  logic        itlb_resp_o, dtlb_resp_o, resp_err_o, stlb_lookup_o, ptw_req_o, ptw_is_instr_o;
  logic        stlb_miss_o, busy_o;
  logic [21:0] resp_ppn_o;
  logic [19:0] stlb_vpn_o, ptw_vpn_o;
  logic [8:0]  stlb_asid_o;
  logic        stlb_hit_i = 0, ptw_ack_i = 0, ptw_done_i = 0, ptw_err_i = 0;
  logic [21:0] stlb_ppn_i = 0, ptw_ppn_i = 0;
  typedef struct packed {logic is_i; logic [21:0] ppn; logic err;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int n_tests = 0, n_fail = 0;

  shared_tlb_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .asid_i(asid_i),
    .itlb_req_i(itlb_req_i), .itlb_vpn_i(itlb_vpn_i),
    .dtlb_req_i(dtlb_req_i), .dtlb_vpn_i(dtlb_vpn_i),
    .itlb_resp_o(itlb_resp_o), .dtlb_resp_o(dtlb_resp_o),
    .resp_ppn_o(resp_ppn_o), .resp_err_o(resp_err_o),
    .stlb_lookup_o(stlb_lookup_o), .stlb_vpn_o(stlb_vpn_o), .stlb_asid_o(stlb_asid_o),
    .stlb_hit_i(stlb_hit_i), .stlb_ppn_i(stlb_ppn_i),
    .ptw_req_o(ptw_req_o), .ptw_vpn_o(ptw_vpn_o), .ptw_is_instr_o(ptw_is_instr_o),
    .ptw_ack_i(ptw_ack_i), .ptw_done_i(ptw_done_i), .ptw_ppn_i(ptw_ppn_i), .ptw_err_i(ptw_err_i),
    .stlb_miss_o(stlb_miss_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  // monitor: every response pulse must match the oldest expected entry
  always @(negedge clk_i) begin
    if (itlb_resp_o || dtlb_resp_o) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got i=%0b d=%0b ppn=0x%0h, no response expected",
                 itlb_resp_o, dtlb_resp_o, resp_ppn_o);
      end else begin
        mon_e = q.pop_front();
        chk("resp_data", {7'd0, itlb_resp_o, dtlb_resp_o, resp_ppn_o, resp_err_o},
            {7'd0, mon_e.is_i, !mon_e.is_i, mon_e.ppn, mon_e.err});
      end
    end
  end

  // starts in the grant cycle with requests already driven; ends after sampling the response cycle
  task automatic serve_hit(input logic is_i, input logic [19:0] vpn, input logic [21:0] ppn);
    smp();
    chk("grant_cycle_idle", busy_o, 0);
    nxt();
    smp();
    chk("lookup_vpn", {stlb_lookup_o, stlb_vpn_o}, {1'b1, vpn});
    chk("lookup_asid", stlb_asid_o, asid_i);
    nxt();
    stlb_hit_i = 1;
    stlb_ppn_i = ppn;
    q.push_back(exp_t'{is_i, ppn, 1'b0});
    smp();
    chk("no_miss_on_hit", {stlb_miss_o, stlb_lookup_o}, 0);
    nxt();
    stlb_hit_i = 0;
    stlb_ppn_i = 0;
    smp();
    chk("resp_cycle3", {itlb_resp_o, dtlb_resp_o}, {is_i, !is_i});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    smp();
    chk("reset_outputs", {busy_o, itlb_resp_o, dtlb_resp_o, stlb_lookup_o, ptw_req_o, stlb_miss_o, resp_err_o}, 0);
    chk("reset_ppn", resp_ppn_o, 0);
    // ITLB-only hit
    nxt();
    rst_ni = 1;
    itlb_req_i = 1;
    itlb_vpn_i = 20'h12345;
    serve_hit(1, 20'h12345, 22'h0ABCD);
    nxt();
    itlb_req_i = 0;
    smp();
    chk("t1_idle", busy_o, 0);
    // simultaneous requests from reset alternate owners
    rst_ni = 0;
    nxt();
    rst_ni = 1;
    itlb_req_i = 1; itlb_vpn_i = 20'h00222;
    dtlb_req_i = 1; dtlb_vpn_i = 20'h00111;
    serve_hit(0, 20'h00111, 22'h1);
    nxt();
    dtlb_vpn_i = 20'h00333;
    serve_hit(1, 20'h00222, 22'h2);
    nxt();
    itlb_vpn_i = 20'h00444;
    serve_hit(0, 20'h00333, 22'h3);
    nxt();
    dtlb_req_i = 0;
    serve_hit(1, 20'h00444, 22'h4);
    nxt();
    itlb_req_i = 0;
    // DTLB miss through the walker with fault
    nxt();
    dtlb_req_i = 1; dtlb_vpn_i = 20'h0AAAA;
    smp();
    nxt(); smp();
    nxt(); smp();
    chk("t3_miss_pulse", stlb_miss_o, 1);
    nxt(); smp();
    chk("t3_ptw_req_c3", {ptw_req_o, ptw_is_instr_o, ptw_vpn_o}, {1'b1, 1'b0, 20'h0AAAA});
    chk("t3_miss_single", stlb_miss_o, 0);
    nxt(); smp();
    chk("t3_ptw_req_c4", ptw_req_o, 1);
    nxt();
    ptw_ack_i = 1;
    smp();
    chk("t3_ptw_req_c5", ptw_req_o, 1);
    nxt();
    ptw_ack_i = 0;
    smp();
    chk("t3_wait", {ptw_req_o, busy_o}, 2'b01);
    nxt();
    ptw_done_i = 1; ptw_ppn_i = 22'h155; ptw_err_i = 1;
    q.push_back(exp_t'{1'b0, 22'h155, 1'b1});
    smp();
    chk("t3_no_early_resp", dtlb_resp_o, 0);
    nxt();
    ptw_done_i = 0; ptw_ppn_i = 0; ptw_err_i = 0;
    smp();
    chk("t3_resp", {dtlb_resp_o, resp_err_o}, 2'b11);
    nxt();
    dtlb_req_i = 0;
    smp();
    chk("t3_idle", busy_o, 0);
    // ITLB miss flushed in PTW_WAIT, drained, then pending DTLB granted
    nxt();
    itlb_req_i = 1; itlb_vpn_i = 20'h00777;
    smp();
    nxt(); smp();
    nxt(); smp();
    chk("t4_miss", stlb_miss_o, 1);
    nxt();
    ptw_ack_i = 1;
    smp();
    chk("t4_is_instr", {ptw_req_o, ptw_is_instr_o}, 2'b11);
    nxt();
    ptw_ack_i = 0; flush_i = 1; itlb_req_i = 0;
    dtlb_req_i = 1; dtlb_vpn_i = 20'h00888;
    smp();
    chk("t4_busy_flush", busy_o, 1);
    nxt();
    flush_i = 0;
    smp();
    chk("t4_drain", {busy_o, ptw_req_o, stlb_lookup_o}, 3'b100);
    for (int i = 0; i < 3; i++) begin
      nxt(); smp();
      chk("t4_drain_busy", {busy_o, stlb_lookup_o}, 2'b10);
    end
    nxt();
    ptw_done_i = 1; ptw_ppn_i = 22'h2AAAA;
    smp();
    chk("t4_done_cycle", {busy_o, stlb_lookup_o, itlb_resp_o}, 3'b100);
    nxt();
    ptw_done_i = 0; ptw_ppn_i = 0;
    serve_hit(0, 20'h00888, 22'h999);
    nxt();
    dtlb_req_i = 0;
    // flush in RESP cycle
    itlb_req_i = 1; itlb_vpn_i = 20'h01234;
    smp();
    nxt(); smp();
    nxt();
    stlb_hit_i = 1; stlb_ppn_i = 22'h5;
    smp();
    nxt();
    stlb_hit_i = 0; stlb_ppn_i = 0; flush_i = 1; itlb_req_i = 0;
    smp();
    chk("t5_flush_resp", {itlb_resp_o, dtlb_resp_o, resp_ppn_o}, 0);
    nxt();
    flush_i = 0;
    smp();
    chk("t5_idle_after_flush", busy_o, 0);
    // ack and done together in PTW_REQ
    dtlb_req_i = 1; dtlb_vpn_i = 20'h0BEEF;
    nxt(); smp();
    nxt(); smp();
    chk("t5_miss", stlb_miss_o, 1);
    nxt();
    ptw_ack_i = 1; ptw_done_i = 1; ptw_ppn_i = 22'h3FFFFF;
    q.push_back(exp_t'{1'b0, 22'h3FFFFF, 1'b0});
    smp();
    chk("t5_ptw_req", ptw_req_o, 1);
    nxt();
    ptw_ack_i = 0; ptw_done_i = 0; ptw_ppn_i = 0;
    smp();
    chk("t5_ackdone_resp", {dtlb_resp_o, resp_ppn_o}, {1'b1, 22'h3FFFFF});
    nxt();
    dtlb_req_i = 0;
    smp();
    chk("t5_idle", busy_o, 0);
    // asynchronous reset in PTW_WAIT
    nxt();
    dtlb_req_i = 1; dtlb_vpn_i = 20'h00010;
    nxt(); nxt(); nxt();
    ptw_ack_i = 1;
    nxt();
    ptw_ack_i = 0;
    smp();
    chk("t6_in_wait", {busy_o, ptw_req_o}, 2'b10);
    #2;
    rst_ni = 0;
    #1;
    chk("t6_async_reset", {busy_o, ptw_req_o, stlb_lookup_o, itlb_resp_o, dtlb_resp_o, stlb_miss_o, ptw_is_instr_o}, 0);
    itlb_req_i = 1; itlb_vpn_i = 20'h00020;
    nxt();
    rst_ni = 1;
    serve_hit(0, 20'h00010, 22'h77);
    nxt();
    dtlb_req_i = 0;
    serve_hit(1, 20'h00020, 22'h78);
    nxt();
    itlb_req_i = 0;
    smp();
    chk("final_idle", busy_o, 0);
    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
